// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access, byte-lane alignment, sign extension, bus timeout.
// Optional LSU_MISALIGN_SPLIT_EN runs word-crossing misaligned accesses as two bus beats.
module lsu_ctrl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2*DATA_W-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  beat_q, beat_d;
  logic                  split_q, split_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic req_illegal;
  logic req_split;
  logic size_bad;
  assign size_bad = (DATA_W == 32) && (req_size == 2'd3);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [OFF_W-1:0] req_off;
  assign req_off     = req_addr[OFF_W-1:0];
  assign req_illegal = size_bad;
  assign req_split   = (int'(req_off) + (1 << req_size)) > BE_W;
`else
  logic [2:0] align_mask;
  always_comb begin
    align_mask = 3'b111;
    case (req_size)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end
  assign req_illegal = size_bad || (|(req_addr[2:0] & align_mask));
  assign req_split   = 1'b0;
`endif

  // Lanes are built over a double-width window so the second beat of a split takes the upper half.
  logic [OFF_W-1:0]    off;
  logic [7:0]          nb_mask;
  logic [2*BE_W-1:0]   be_full;
  logic [2*DATA_W-1:0] wdata_full;
  logic [ADDR_W-1:0]   base_addr;
  logic                in_req;

  assign off = addr_q[OFF_W-1:0];
  always_comb begin
    nb_mask = 8'hFF;
    case (size_q)
      2'd0: nb_mask = 8'h01;
      2'd1: nb_mask = 8'h03;
      2'd2: nb_mask = 8'h0F;
      default: nb_mask = 8'hFF;
    endcase
  end
  assign be_full    = (2*BE_W)'(nb_mask) << off;
  assign wdata_full = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
  assign base_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign in_req     = (state_q == REQ);

  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? (base_addr + (beat_q ? ADDR_W'(BE_W) : '0)) : '0;
  assign mem_be    = in_req ? (beat_q ? be_full[2*BE_W-1:BE_W] : be_full[BE_W-1:0]) : '0;
  assign mem_wdata = in_req ? (beat_q ? wdata_full[2*DATA_W-1:DATA_W] : wdata_full[DATA_W-1:0]) : '0;

  logic [DATA_W-1:0] load_lo;
  logic [DATA_W-1:0] load_ext;
  logic [3:0]        nbytes;
  logic [IDX_W-1:0]  sign_idx;
  logic              fill;

  assign load_lo  = DATA_W'(rdata_q >> {off, 3'b000});
  assign nbytes   = 4'd1 << size_q;
  assign sign_idx = IDX_W'((8 << size_q) - 1);
  assign fill     = ~uns_q & load_lo[sign_idx];

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign load_ext[8*gi +: 8] = (4'(gi) < nbytes) ? load_lo[8*gi +: 8] : {8{fill}};
    end
  endgenerate

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !we_q) ? load_ext : '0;

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (({1'b0, cnt_q} + 1'b1) == (CNT_W+1)'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    beat_d  = beat_q;
    split_d = split_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          beat_d  = 1'b0;
          split_d = req_split;
          cnt_d   = '0;
          err_d   = req_illegal;
          state_d = req_illegal ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          err_d = err_q | mem_err;
          if (beat_q) rdata_d[2*DATA_W-1:DATA_W] = mem_rdata;
          else        rdata_d[DATA_W-1:0]        = mem_rdata;
          if (split_q && !beat_q) begin
            beat_d  = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            state_d = RESP;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      beat_q  <= 1'b0;
      split_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      split_q <= split_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (DATA_W=32, TIMEOUT_CYCLES=4) with a response scoreboard.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt = 1'b0, mem_we, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rsp_cyc = 0;
  int   rsp_cnt = 0;
  int   exp_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        $display("rsp: err=%0b rdata=%08h (expected err=%0b rdata=%08h)",
                 rsp_err, rsp_rdata, mon_e.err, mon_e.rdata);
      end
    end
  end

  // Presents one request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic push, input logic exp_err, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    acc_cyc = cyc;
    if (push) begin
      sb_q.push_back({exp_err, exp_rdata});
      exp_rsp++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // One bus beat: holds gnt low for gdly cycles, then optionally returns rvalid next cycle.
  task automatic bus_beat(input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic ewe, input int gdly, input logic give_rv,
                          input logic [31:0] rd, input logic me);
    for (int i = 0; i <= gdly; i++) begin
      mem_gnt = (i == gdly);
      @(negedge clk);
      check("mem_req", 64'(mem_req), 64'd1);
      check("mem_addr", 64'(mem_addr), 64'(ea));
      check("mem_be", 64'(mem_be), 64'(ebe));
      check("mem_wdata", 64'(mem_wdata), 64'(ewd));
      check("mem_we", 64'(mem_we), 64'(ewe));
      check("req_ready_busy", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    if (give_rv) begin
      mem_rvalid = 1'b1; mem_rdata = rd; mem_err = me;
      @(negedge clk);
      check("mem_req_wait", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    end
  endtask

  task automatic expect_rsp(input string tag);
    @(negedge clk);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_mem_req_resp"}, 64'(mem_req), 64'd0);
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
    check({tag, "_ready_again"}, 64'(req_ready), 64'd1);
    $display("txn %s done at cycle %0d", tag, cyc);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Signed byte load from the top lane, fastest bus: 3-cycle latency.
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80);
    bus_beat(32'h100, 4'b1000, 32'h0, 1'b0, 0, 1'b1, 32'h80FF_FF12, 1'b0);
    expect_rsp("ld_byte_signed");
    check("latency", 64'(rsp_cyc - acc_cyc), 64'd3);

    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 1'b1, 1'b0, 32'h0);
    bus_beat(32'h200, 4'b1100, 32'hABCD_0000, 1'b1, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    expect_rsp("st_half");

    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 32'h0000_8234);
    bus_beat(32'h100, 4'b1100, 32'h0, 1'b0, 0, 1'b1, 32'h8234_5678, 1'b0);
    expect_rsp("ld_half_unsigned");

    issue(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hFFFF_F00D);
    bus_beat(32'h100, 4'b0011, 32'h0, 1'b0, 0, 1'b1, 32'h1234_F00D, 1'b0);
    expect_rsp("ld_half_signed");

    issue(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 32'h0000_009A);
    bus_beat(32'h100, 4'b0010, 32'h0, 1'b0, 0, 1'b1, 32'h0000_9A00, 1'b0);
    expect_rsp("ld_byte_unsigned");

    issue(1'b1, 2'd2, 1'b0, 32'h304, 32'h1122_3344, 1'b1, 1'b1, 32'h0);
    bus_beat(32'h304, 4'b1111, 32'h1122_3344, 1'b1, 0, 1'b1, 32'h0, 1'b1);
    expect_rsp("st_word_bus_err");

    // Grant stalled 3 cycles while a second request is held on the core port.
    issue(1'b1, 2'd0, 1'b0, 32'h301, 32'h0000_005A, 1'b1, 1'b0, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h700; req_wdata = 32'hFFFF_FFFF;
    bus_beat(32'h300, 4'b0010, 32'h0000_5A00, 1'b1, 3, 1'b1, 32'h0, 1'b0);
    req_valid = 1'b0;
    expect_rsp("st_byte_gnt_stall");

    issue(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 32'h0);
    expect_rsp("illegal_dword");

`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    bus_beat(32'h0FC, 4'b1100, 32'h0, 1'b0, 0, 1'b1, 32'h5678_0000, 1'b0);
    bus_beat(32'h100, 4'b0011, 32'h0, 1'b0, 0, 1'b1, 32'h0000_1234, 1'b0);
    expect_rsp("ld_word_split");
    issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1'b1, 1'b0, 32'hFFFF_ABCD);
    bus_beat(32'h100, 4'b0110, 32'h0, 1'b0, 0, 1'b1, 32'h00AB_CD00, 1'b0);
    expect_rsp("ld_half_misaligned");
`else
    issue(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 1'b1, 1'b1, 32'h0);
    expect_rsp("ld_word_misaligned");
    issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1'b1, 1'b1, 32'h0);
    expect_rsp("ld_half_misaligned");
`endif

    // Granted but never answered: four WAIT cycles, then an error response.
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0);
    bus_beat(32'h400, 4'b1111, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("timeout_no_rsp_yet", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    expect_rsp("timeout");
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("late_rvalid_ignored", 64'(rsp_valid), 64'd0);
    check("late_rvalid_ready", 64'(req_ready), 64'd1);

    // Reset while waiting on the bus abandons the access.
    issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0);
    bus_beat(32'h500, 4'b1111, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    check("mid_reset_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("stale_rvalid_ignored", 64'(rsp_valid), 64'd0);
    $display("txn mid_reset abandoned at cycle %0d", cyc);

    issue(1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
    bus_beat(32'h504, 4'b1111, 32'h0, 1'b0, 0, 1'b1, 32'hCAFE_F00D, 1'b0);
    expect_rsp("ld_word_after_reset");

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("rsp_count", 64'(rsp_cnt), 64'(exp_rsp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the bus data width; legal values 32, 64.
REQ-003 Parameter ADDR_W, default 32, SHALL set the byte address width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the memory wait limit; 0 disables the timeout.
REQ-005 Ports SHALL be, one per line: name, direction, width, meaning.
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 req_valid  in  1  core access request
 req_ready  out  1  block can accept a request
 req_we  in  1  1 = store, 0 = load
 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
 req_unsigned  in  1  zero-extend load data
 req_addr  in  ADDR_W  byte address
 req_wdata  in  DATA_W  store data, LSB-justified
 rsp_valid  out  1  one-cycle completion pulse
 rsp_rdata  out  DATA_W  extended load data; 0 for stores
 rsp_err  out  1  access error, valid with rsp_valid
 mem_req  out  1  bus request
 mem_gnt  in  1  bus accepts request
 mem_we  out  1  bus write
 mem_addr  out  ADDR_W  bus address, aligned to DATA_W/8
 mem_be  out  DATA_W/8  byte enables
 mem_wdata  out  DATA_W  lane-shifted store data
 mem_rvalid  in  1  bus response
 mem_rdata  in  DATA_W  bus read data
 mem_err  in  1  bus error, valid with mem_rvalid

Function
REQ-006 States SHALL be IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-007 On req_valid & req_ready all request fields SHALL be registered and the FSM SHALL go to REQ, or to RESP with rsp_err=1 if the access is illegal.
REQ-008 Illegal: req_size=3 when DATA_W=32, or misaligned (addr mod 2^size != 0) when LSU_MISALIGN_SPLIT_EN is undefined.
REQ-009 In REQ, mem_req SHALL be 1 and mem_we/addr/be/wdata SHALL stay stable until the cycle mem_gnt=1; then go to WAIT.
REQ-010 mem_addr = addr with low log2(DATA_W/8) bits cleared; mem_be = ((1<<2^size)-1) << offset; mem_wdata = req_wdata << 8*offset; offset = addr low bits.
REQ-011 In WAIT, mem_rvalid SHALL move the FSM to RESP, capturing mem_rdata and mem_err; mem_rvalid outside WAIT SHALL be ignored.
REQ-012 Load data SHALL be shifted right by 8*offset, masked to 2^size bytes, sign-extended from the top byte unless req_unsigned or the size equals DATA_W.
REQ-013 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; request-to-rsp_valid latency with gnt and rvalid each in the first cycle possible SHALL be 3 cycles.
REQ-014 A counter SHALL clear on entering REQ and on every gnt, and increment each cycle in REQ or WAIT; reaching TIMEOUT_CYCLES SHALL force RESP with rsp_err=1 and mem_req=0.
REQ-015 Only one access SHALL be outstanding; req_valid outside IDLE SHALL be ignored.

Reset
REQ-016 rst SHALL force IDLE, counter 0, req_ready=1 (after release), and rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata all 0.
REQ-017 Reset mid-access SHALL abandon it with no rsp_valid; a later stale mem_rvalid SHALL be ignored.

Configuration
REQ-018 With LSU_MISALIGN_SPLIT_EN defined, a misaligned access crossing a bus word SHALL run as two REQ/WAIT beats (lower word, then mem_addr + DATA_W/8) with split be/wdata; load bytes merged; rsp_err = OR of both mem_err; one rsp_valid.
REQ-019 Without LSU_MISALIGN_SPLIT_EN, misaligned accesses SHALL produce rsp_err=1 with no mem_req.

Verification
REQ-020 DATA_W=32, load byte addr 0x103, mem_rdata 0x80FF_FF12, signed -> mem_be 4'b1000, rsp_rdata 0xFFFF_FF80.
REQ-021 Store half 0xABCD to 0x202 -> mem_addr 0x200, mem_be 4'b1100, mem_wdata 0xABCD_0000, rsp_rdata 0.
REQ-022 mem_gnt held low 3 cycles -> mem_req and fields stable 4 cycles, single rsp_valid.
REQ-023 TIMEOUT_CYCLES=4, no mem_rvalid -> rsp_err=1 after 4 WAIT cycles; late mem_rvalid ignored.
REQ-024 Word load 0x0FE: macro off -> rsp_err, no mem_req; macro on -> beats at 0x0FC (be 1100) and 0x100 (be 0011), merged word.
REQ-025 rst asserted during WAIT -> IDLE next cycle, no rsp_valid, outputs 0.
